// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: FSM state encoding and the load/store ALU op codes
// that the execute-stage decoder also uses.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [4:0]  LSU_OP_LW           = 5'b10100;
  localparam logic [4:0]  LSU_OP_SW           = 5'b10101;
  localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

  function automatic logic lsu_is_mem_op(input logic [4:0] op,
                                         input logic [4:0] op_lw,
                                         input logic [4:0] op_sw);
    return (op == op_lw) || (op == op_sw);
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-bus interface between the LSU (master) and the memory/bus fabric (slave).
interface lsu_ctrl_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/lsu_timeout_cnt.sv
// Saturating wait counter; o_expired flags the cycle in which the count reaches LIMIT.
module lsu_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int unsigned     CW      = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign o_expired = i_enable & (w_cnt_inc == LIMIT_C);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT_C)) begin
      r_cnt <= w_cnt_inc;
    end
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: stalls the pipeline around a single bus access.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects non-word-aligned accesses.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
  parameter logic [4:0]  OP_LW          = LSU_OP_LW,
  parameter logic [4:0]  OP_SW          = LSU_OP_SW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_en_i,
  input  logic [4:0]  alu_op_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  lsu_ctrl_if.master  bus
);
  localparam logic [1:0] S_IDLE = LSU_IDLE;
  localparam logic [1:0] S_REQ  = LSU_REQ;
  localparam logic [1:0] S_RSP  = LSU_RSP;
  localparam logic [1:0] S_DONE = LSU_DONE;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_we;
  logic        r_err;

  logic [1:0]  w_state_next;
  logic        w_mem_acc;
  logic        w_misalign;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic        w_expired;
  logic        w_bus_act;

  assign w_mem_acc = valid_i & mem_en_i & lsu_is_mem_op(alu_op_i, OP_LW, OP_SW);

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = (alu_out_i[1:0] != 2'b00);
`else
  logic w_unused_lsb;
  assign w_misalign   = 1'b0;
  assign w_unused_lsb = ^alu_out_i[1:0];
`endif

  assign w_cnt_en = (r_state == S_REQ) | (r_state == S_RSP);

  lsu_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cnt_clr),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  // A grant or response in the same cycle as expiry still completes normally.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_mem_acc) begin
          w_state_next = w_misalign ? S_DONE : S_REQ;
          w_cnt_clr    = ~w_misalign;
        end
      end
      S_REQ: begin
        if (bus.bus_gnt_i) begin
          w_state_next = r_we ? S_DONE : S_RSP;
          w_cnt_clr    = ~r_we;
        end else if (w_expired) begin
          w_state_next = S_DONE;
        end
      end
      S_RSP: begin
        if (bus.bus_rvalid_i || w_expired) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && w_mem_acc) begin
        r_addr  <= {alu_out_i[31:2], 2'b00};
        r_wdata <= store_data_i;
        r_we    <= (alu_op_i == OP_SW);
        r_err   <= w_misalign;
      end
      if ((r_state == S_REQ) && !bus.bus_gnt_i && w_expired) begin
        r_err <= 1'b1;
      end
      if (r_state == S_RSP) begin
        if (bus.bus_rvalid_i) begin
          r_rdata <= bus.bus_rdata_i;
        end else if (w_expired) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Outputs are forced low while rst is held, even before the registers clear.
  always_comb begin
    stall_o    = 1'b0;
    wb_valid_o = 1'b0;
    wb_data_o  = '0;
    err_o      = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mem_acc) begin
            stall_o = 1'b1;
          end else if (valid_i) begin
            wb_valid_o = 1'b1;
            wb_data_o  = alu_out_i;
          end
        end
        S_REQ, S_RSP: stall_o = 1'b1;
        default: begin
          err_o      = r_err;
          wb_valid_o = ~r_we & ~r_err;
          wb_data_o  = (~r_we & ~r_err) ? r_rdata : '0;
        end
      endcase
    end
  end

  assign w_bus_act       = ~rst & (r_state == S_REQ);
  assign bus.bus_req_o   = w_bus_act;
  assign bus.bus_we_o    = w_bus_act & r_we;
  assign bus.bus_addr_o  = w_bus_act ? r_addr  : '0;
  assign bus.bus_wdata_o = w_bus_act ? r_wdata : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stimulus pushes expected bus handshakes, write-backs
// and error pulses into a scoreboard that a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lsu_ctrl;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_SW  = 5'b10101;
  localparam logic [4:0] OP_ADD = 5'b01101;
  localparam logic [1:0] K_WB   = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_BUS  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        mem_en_i;
  logic [4:0]  alu_op_i;
  logic [31:0] alu_out_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  lsu_ctrl_if bus_if ();

  lsu_ctrl #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .mem_en_i     (mem_en_i),
    .alu_op_i     (alu_op_i),
    .alu_out_i    (alu_out_i),
    .store_data_i (store_data_i),
    .stall_o      (stall_o),
    .wb_valid_o   (wb_valid_o),
    .wb_data_o    (wb_data_o),
    .err_o        (err_o),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic we,
                          input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e = {kind, we, addr, data};
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input exp_t act, input string nm);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: actual kind=%0d we=%0b addr=0x%08h data=0x%08h required=no event",
               nm, act.kind, act.we, act.addr, act.data);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_errors++;
        $display("FAIL %s: actual kind=%0d we=%0b addr=0x%08h data=0x%08h required kind=%0d we=%0b addr=0x%08h data=0x%08h",
                 nm, act.kind, act.we, act.addr, act.data, e.kind, e.we, e.addr, e.data);
      end else begin
        $display("txn %s kind=%0d we=%0b addr=0x%08h data=0x%08h ok", nm, act.kind, act.we, act.addr, act.data);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t a;
    if (wb_valid_o) begin
      a = {K_WB, 1'b0, 32'h0, wb_data_o};
      sb_pop(a, "sb_wb");
    end
    if (err_o) begin
      a = {K_ERR, 1'b0, 32'h0, 32'h0};
      sb_pop(a, "sb_err");
    end
    if (bus_if.bus_req_o && bus_if.bus_gnt_i) begin
      a = {K_BUS, bus_if.bus_we_o, bus_if.bus_addr_o, bus_if.bus_wdata_o};
      sb_pop(a, "sb_bus");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_i             = 1'b0;
    mem_en_i            = 1'b0;
    alu_op_i            = 5'd0;
    alu_out_i           = 32'h0;
    store_data_i        = 32'h0;
    bus_if.bus_gnt_i    = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    bus_if.bus_rdata_i  = 32'h0;
  endtask

  function automatic logic [31:0] ctl_bits();
    return {27'd0, stall_o, wb_valid_o, err_o, bus_if.bus_req_o, bus_if.bus_we_o};
  endfunction

  task automatic alu_op(input logic mem_en, input logic [4:0] op,
                        input logic [31:0] val, input string nm);
    idle_in();
    valid_i = 1'b1; mem_en_i = mem_en; alu_op_i = op; alu_out_i = val;
    push_exp(K_WB, 1'b0, 32'h0, val);
    @(negedge clk);
    chk({nm, "_stall"}, stall_o, 0);
    step();
    idle_in();
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [31:0] rdata, input string nm);
    int stalls;
    stalls = 0;
    idle_in();
    valid_i = 1'b1; mem_en_i = 1'b1; alu_op_i = OP_LW; alu_out_i = addr;
    push_exp(K_BUS, 1'b0, exp_addr, 32'h0);
    push_exp(K_WB, 1'b0, 32'h0, rdata);
    @(negedge clk); stalls += int'(stall_o);
    step(); idle_in(); bus_if.bus_gnt_i = 1'b1;
    @(negedge clk); stalls += int'(stall_o);
    step(); idle_in(); bus_if.bus_rvalid_i = 1'b1; bus_if.bus_rdata_i = rdata;
    @(negedge clk); stalls += int'(stall_o);
    chk({nm, "_rsp_req_low"}, bus_if.bus_req_o, 0);
    // A new ALU result presented during DONE must not be decoded.
    step(); idle_in(); valid_i = 1'b1; alu_out_i = 32'h77;
    @(negedge clk);
    chk({nm, "_wb_4th_cycle"}, wb_valid_o, 1);
    chk({nm, "_done_stall"}, stall_o, 0);
    chk({nm, "_stall_cycles"}, stalls, 3);
    step(); idle_in();
  endtask

  task automatic do_timeout(input logic give_gnt, input logic [31:0] addr,
                            input int exp_wait, input string nm);
    int waited;
    bit seen;
    waited = 0; seen = 0;
    idle_in();
    valid_i = 1'b1; mem_en_i = 1'b1; alu_op_i = OP_LW; alu_out_i = addr;
    if (give_gnt) push_exp(K_BUS, 1'b0, addr, 32'h0);
    push_exp(K_ERR, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int c = 0; c < 40 && !seen; c++) begin
      step(); idle_in(); bus_if.bus_gnt_i = give_gnt && (c == 0);
      @(negedge clk);
      if (err_o) begin
        seen = 1;
        chk({nm, "_err_ctl"}, {29'd0, bus_if.bus_req_o, wb_valid_o, stall_o}, 0);
      end else if (stall_o) begin
        waited++;
      end
    end
    chk({nm, "_err_seen"}, seen, 1);
    chk({nm, "_wait_cycles"}, waited, exp_wait);
    step(); idle_in();
    @(negedge clk);
    chk({nm, "_back_idle"}, ctl_bits(), 0);
  endtask

  initial begin
    int stable;
    int stalls;

    // Reset holds every output low even with a valid ALU result present.
    idle_in();
    rst = 1'b1; valid_i = 1'b1; alu_out_i = 32'h55;
    @(negedge clk);
    chk("rst_ctl", ctl_bits(), 0);
    chk("rst_wb_data", wb_data_o, 0);
    step(); step();
    rst = 1'b0; idle_in();
    @(negedge clk);
    chk("idle_quiet", ctl_bits(), 0);
    step();

    alu_op(1'b0, OP_ADD, 32'h0000_0042, "add");
    alu_op(1'b0, OP_LW,  32'h0000_1000, "jalr");
    alu_op(1'b1, OP_ADD, 32'h0000_0007, "memen_nonmem");

    do_load(32'h0000_0100, 32'h0000_0100, 32'hDEAD_BEEF, "load");

    // Store with grant held off for five REQ cycles; stray rvalid must be ignored.
    idle_in();
    valid_i = 1'b1; mem_en_i = 1'b1; alu_op_i = OP_SW;
    alu_out_i = 32'h0000_0204; store_data_i = 32'h1234_5678;
    push_exp(K_BUS, 1'b1, 32'h0000_0204, 32'h1234_5678);
    stable = 0; stalls = 0;
    @(negedge clk); stalls += int'(stall_o);
    for (int c = 0; c < 6; c++) begin
      step(); idle_in();
      bus_if.bus_gnt_i = (c == 5); bus_if.bus_rvalid_i = (c < 5); bus_if.bus_rdata_i = 32'hBAD0_BAD0;
      @(negedge clk); stalls += int'(stall_o);
      if (bus_if.bus_req_o && bus_if.bus_we_o && bus_if.bus_addr_o == 32'h0000_0204 &&
          bus_if.bus_wdata_o == 32'h1234_5678)
        stable++;
    end
    chk("store_stable_cycles", stable, 6);
    chk("store_stall_cycles", stalls, 7);
    step(); idle_in(); valid_i = 1'b1; alu_out_i = 32'h99;
    @(negedge clk);
    chk("store_done_ctl", ctl_bits(), 0);
    step(); idle_in();

    do_timeout(1'b0, 32'h0000_0300, 16, "tmo_req");
    do_timeout(1'b1, 32'h0000_0304, 17, "tmo_rsp");
    step();

    // Reset while waiting for the load response.
    idle_in();
    valid_i = 1'b1; mem_en_i = 1'b1; alu_op_i = OP_LW; alu_out_i = 32'h0000_0400;
    push_exp(K_BUS, 1'b0, 32'h0000_0400, 32'h0);
    @(negedge clk);
    step(); idle_in(); bus_if.bus_gnt_i = 1'b1;
    @(negedge clk);
    step(); idle_in(); rst = 1'b1;
    @(negedge clk);
    chk("rst_rsp_ctl", ctl_bits(), 0);
    chk("rst_rsp_addr", bus_if.bus_addr_o, 0);
    chk("rst_rsp_wb_data", wb_data_o, 0);
    step(); rst = 1'b0; bus_if.bus_rvalid_i = 1'b1; bus_if.bus_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rst_rsp_next_ctl", ctl_bits(), 0);
    step(); idle_in();
    @(negedge clk);
    chk("rst_rsp_after_ctl", ctl_bits(), 0);
    step();

`ifdef LSU_MISALIGN_CHECK_EN
    idle_in();
    valid_i = 1'b1; mem_en_i = 1'b1; alu_op_i = OP_LW; alu_out_i = 32'h0000_0102;
    push_exp(K_ERR, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("misalign_stall", {31'd0, stall_o}, 1);
    chk("misalign_req", bus_if.bus_req_o, 0);
    step(); idle_in();
    @(negedge clk);
    chk("misalign_err", {29'd0, err_o, bus_if.bus_req_o, stall_o}, 32'h4);
    step(); idle_in();
`else
    do_load(32'h0000_0102, 32'h0000_0100, 32'hCAFE_F00D, "unaligned");
`endif

    step(); step();
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
